// File: rtl/crc_msg_buffer_if.sv
// Bus bundle for crc_msg_buffer: byte-stream input, RAM read port and CRC controller handshake.
interface crc_msg_buffer_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned CRC_W  = 16;

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [CRC_W-1:0]  crc_out_target;
  logic              crc_start;
  logic              crc_rdy;
  logic              crc_ok;
  logic              frame_done;
  logic              frame_ok;
  logic              frame_err;

  // Buffer side
  modport slave (
    input  s_data, s_valid, s_last, mem_addr, crc_rdy, crc_ok,
    output s_ready, mem_data, crc_out_target, crc_start, frame_done, frame_ok, frame_err
  );

  // Upstream source / CRC controller side
  modport master (
    output s_data, s_valid, s_last, mem_addr, crc_rdy, crc_ok,
    input  s_ready, mem_data, crc_out_target, crc_start, frame_done, frame_ok, frame_err
  );
endinterface

// File: rtl/crc_msg_buffer.sv
// Frame buffer ahead of the CRC checker: stores payload in a 1024x8 RAM, captures the 16-bit trailer,
// starts the controller and reports the verdict. Optional macro CRC_LSB_FIRST_EN selects low-byte-first trailer.
module crc_msg_buffer #(
  parameter int unsigned MSG_LEN = 1024,
  parameter int unsigned BUSY_TO = 15
) (
  input logic            clk50m,
  input logic            rst_n,
  crc_msg_buffer_if.slave bus
);

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned AW      = 10;
  localparam int unsigned DW      = 8;
  localparam int unsigned CW      = 16;
  localparam int unsigned TW      = $clog2(BUSY_TO + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(MSG_LEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TO - 1);

`ifdef CRC_LSB_FIRST_EN
  localparam int unsigned FIRST_LSB  = 0;
  localparam int unsigned SECOND_LSB = 8;
`else
  localparam int unsigned FIRST_LSB  = 8;
  localparam int unsigned SECOND_LSB = 0;
`endif

  typedef enum logic [2:0] {
    RX_PAY,
    RX_CRC_HI,
    RX_CRC_LO,
    DRAIN,
    START,
    WAIT_BUSY,
    WAIT_RDY
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [TW-1:0] r_timer;
  logic          r_s_ready;
  logic          r_crc_start;
  logic          r_frame_done;
  logic          r_frame_ok;
  logic          r_frame_err;
  logic [CW-1:0] r_crc_target;
  logic [DW-1:0] r_mem_data;
  logic [DW-1:0] r_mem [DEPTH];

  logic w_accept;
  logic w_wr_en;

  assign w_accept = bus.s_valid & r_s_ready;
  assign w_wr_en  = w_accept & (r_state == RX_PAY);

  // Frame sequencing; s_ready is registered from the next state so it drops the cycle START is entered
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RX_PAY;
      r_wr_ptr     <= '0;
      r_timer      <= '0;
      r_s_ready    <= 1'b1;
      r_crc_start  <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_ok   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_crc_target <= '0;
    end else begin
      r_crc_start  <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        RX_PAY: begin
          if (w_accept) begin
            if (bus.s_last) begin
              r_frame_err <= 1'b1;
              r_wr_ptr    <= '0;
            end else if (r_wr_ptr == LAST_PTR) begin
              r_wr_ptr <= '0;
              r_state  <= RX_CRC_HI;
            end else begin
              r_wr_ptr <= r_wr_ptr + AW'(1);
            end
          end
        end
        RX_CRC_HI: begin
          if (w_accept) begin
            if (bus.s_last) begin
              r_frame_err <= 1'b1;
              r_wr_ptr    <= '0;
              r_state     <= RX_PAY;
            end else begin
              r_crc_target[FIRST_LSB +: 8] <= bus.s_data;
              r_state                      <= RX_CRC_LO;
            end
          end
        end
        RX_CRC_LO: begin
          if (w_accept) begin
            r_crc_target[SECOND_LSB +: 8] <= bus.s_data;
            if (bus.s_last) begin
              r_crc_start <= 1'b1;
              r_s_ready   <= 1'b0;
              r_timer     <= '0;
              r_state     <= START;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_accept && bus.s_last) begin
            r_wr_ptr <= '0;
            r_state  <= RX_PAY;
          end
        end
        START: begin
          // Timer counts from the crc_start cycle so the timeout lands BUSY_TO cycles after the pulse
          r_timer <= r_timer + TW'(1);
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!bus.crc_rdy) begin
            r_state <= WAIT_RDY;
          end else if (r_timer == TO_LAST) begin
            r_frame_err <= 1'b1;
            r_wr_ptr    <= '0;
            r_s_ready   <= 1'b1;
            r_state     <= RX_PAY;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        WAIT_RDY: begin
          if (bus.crc_rdy) begin
            r_frame_ok   <= bus.crc_ok;
            r_frame_done <= 1'b1;
            r_wr_ptr     <= '0;
            r_s_ready    <= 1'b1;
            r_state      <= RX_PAY;
          end
        end
        default: begin
          r_s_ready <= 1'b1;
          r_state   <= RX_PAY;
        end
      endcase
    end
  end

  // Payload RAM write port; contents survive reset
  always_ff @(posedge clk50m) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= bus.s_data;
    end
  end

  // Registered read port; same-address write in the same cycle returns the old byte
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_data <= '0;
    end else begin
      r_mem_data <= r_mem[bus.mem_addr];
    end
  end

  assign bus.s_ready        = r_s_ready;
  assign bus.mem_data       = r_mem_data;
  assign bus.crc_out_target = r_crc_target;
  assign bus.crc_start      = r_crc_start;
  assign bus.frame_done     = r_frame_done;
  assign bus.frame_ok       = r_frame_ok;
  assign bus.frame_err      = r_frame_err;

endmodule

// File: tb/tb_crc_msg_buffer.sv
// Directed self-checking bench for crc_msg_buffer with a 4-byte payload and a scripted CRC controller.
module tb_crc_msg_buffer;

  localparam int unsigned MSG_LEN = 4;
  localparam int unsigned BUSY_TO = 15;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  crc_msg_buffer_if bus ();

  crc_msg_buffer #(
    .MSG_LEN (MSG_LEN),
    .BUSY_TO (BUSY_TO)
  ) dut (
    .clk50m (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp16(input logic [7:0] first, input logic [7:0] second);
`ifdef CRC_LSB_FIRST_EN
    return {second, first};
`else
    return {first, second};
`endif
  endfunction

  // Present one byte and hold it until accepted, bounded
  task automatic send(input logic [7:0] d, input logic last);
    logic rdy;
    bit   done;
    done        = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    for (int i = 0; i < 40 && !done; i++) begin
      rdy = bus.s_ready;
      tick();
      if (rdy) done = 1'b1;
    end
    if (!done) chk("send_accept_timeout", 32'd0, 32'd1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // Idle gap with junk on data/last that must be ignored, then send
  task automatic send_gap(input logic [7:0] d, input logic last);
    int unsigned gap;
    gap        = $urandom_range(0, 3);
    bus.s_data = 8'hEE;
    bus.s_last = 1'b1;
    repeat (gap) tick();
    send(d, last);
  endtask

  // Called right after the trailer low byte is accepted; plays the controller
  task automatic finish_frame(input logic ok, input logic [15:0] tgt);
    chk("start_pulse", 32'(bus.crc_start), 32'd1);
    chk("start_sready", 32'(bus.s_ready), 32'd0);
    chk("start_target", 32'(bus.crc_out_target), 32'(tgt));
    tick();
    chk("start_one_cycle", 32'(bus.crc_start), 32'd0);
    bus.crc_rdy = 1'b0;
    repeat (3) begin
      tick();
      chk("busy_no_done", 32'(bus.frame_done), 32'd0);
      chk("busy_sready", 32'(bus.s_ready), 32'd0);
    end
    bus.crc_rdy = 1'b1;
    bus.crc_ok  = ok;
    tick();
    chk("done_pulse", 32'(bus.frame_done), 32'd1);
    chk("done_ok", 32'(bus.frame_ok), 32'(ok));
    chk("done_sready", 32'(bus.s_ready), 32'd1);
    chk("done_no_err", 32'(bus.frame_err), 32'd0);
    bus.crc_ok = ~ok;
    tick();
    chk("done_one_cycle", 32'(bus.frame_done), 32'd0);
    chk("ok_held", 32'(bus.frame_ok), 32'(ok));
    chk("target_held", 32'(bus.crc_out_target), 32'(tgt));
    bus.crc_ok = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.s_data   = '0;
    bus.s_valid  = 1'b0;
    bus.s_last   = 1'b0;
    bus.mem_addr = '0;
    bus.crc_rdy  = 1'b1;
    bus.crc_ok   = 1'b0;
    repeat (3) tick();
    chk("rst_sready", 32'(bus.s_ready), 32'd1);
    chk("rst_start", 32'(bus.crc_start), 32'd0);
    chk("rst_done", 32'(bus.frame_done), 32'd0);
    chk("rst_ok", 32'(bus.frame_ok), 32'd0);
    chk("rst_err", 32'(bus.frame_err), 32'd0);
    chk("rst_target", 32'(bus.crc_out_target), 32'h0);
    chk("rst_memdata", 32'(bus.mem_data), 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Clean frame, controller reports OK
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    send(8'hAB, 1'b0);
    chk("hi_no_start", 32'(bus.crc_start), 32'd0);
    send(8'hCD, 1'b1);
    finish_frame(1'b1, exp16(8'hAB, 8'hCD));

    // Read port latency and sweep
    bus.mem_addr = 10'd2;
    tick();
    chk("rd_addr2", 32'(bus.mem_data), 32'h03);
    for (int i = 0; i < 4; i++) begin
      bus.mem_addr = 10'(i);
      tick();
      chk("rd_sweep", 32'(bus.mem_data), 32'(i + 1));
    end

    // Early s_last on payload byte 3; also read-during-write on address 0
    bus.mem_addr = 10'd0;
    tick();
    send(8'h55, 1'b0);
    chk("rdw_old_data", 32'(bus.mem_data), 32'h01);
    send(8'h66, 1'b0);
    chk("rdw_new_data", 32'(bus.mem_data), 32'h55);
    send(8'h77, 1'b1);
    chk("early_err", 32'(bus.frame_err), 32'd1);
    chk("early_no_start", 32'(bus.crc_start), 32'd0);
    chk("early_sready", 32'(bus.s_ready), 32'd1);
    tick();
    chk("early_err_pulse", 32'(bus.frame_err), 32'd0);
    chk("early_no_start2", 32'(bus.crc_start), 32'd0);

    // Next clean frame, controller reports bad CRC
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    send(8'h12, 1'b0);
    send(8'h34, 1'b1);
    finish_frame(1'b0, exp16(8'h12, 8'h34));
    bus.mem_addr = 10'd0;
    tick();
    chk("rd_after_early0", 32'(bus.mem_data), 32'h11);
    bus.mem_addr = 10'd3;
    tick();
    chk("rd_after_early3", 32'(bus.mem_data), 32'h44);

    // Missing s_last on trailer, drained by two extra bytes
    send(8'h21, 1'b0);
    send(8'h22, 1'b0);
    send(8'h23, 1'b0);
    send(8'h24, 1'b0);
    send(8'hA1, 1'b0);
    send(8'hB2, 1'b0);
    chk("nolast_err", 32'(bus.frame_err), 32'd1);
    chk("nolast_no_start", 32'(bus.crc_start), 32'd0);
    chk("nolast_sready", 32'(bus.s_ready), 32'd1);
    send(8'hEE, 1'b0);
    chk("drain_err_once", 32'(bus.frame_err), 32'd0);
    send(8'hFF, 1'b1);
    chk("drain_end_err", 32'(bus.frame_err), 32'd0);
    chk("drain_end_start", 32'(bus.crc_start), 32'd0);
    chk("drain_end_sready", 32'(bus.s_ready), 32'd1);
    bus.mem_addr = 10'd0;
    tick();
    chk("drain_no_write", 32'(bus.mem_data), 32'h21);

    // Timeout: controller never drops crc_rdy
    send(8'h31, 1'b0);
    send(8'h32, 1'b0);
    send(8'h33, 1'b0);
    send(8'h34, 1'b0);
    send(8'h5A, 1'b0);
    send(8'hA5, 1'b1);
    bus.crc_ok = 1'b1;
    chk("to_start", 32'(bus.crc_start), 32'd1);
    for (int k = 1; k < int'(BUSY_TO); k++) begin
      tick();
      chk("to_not_yet", 32'(bus.frame_err), 32'd0);
    end
    tick();
    chk("to_err", 32'(bus.frame_err), 32'd1);
    chk("to_no_done", 32'(bus.frame_done), 32'd0);
    chk("to_ok_unchanged", 32'(bus.frame_ok), 32'd0);
    chk("to_sready", 32'(bus.s_ready), 32'd1);
    bus.crc_ok = 1'b0;
    tick();
    chk("to_err_pulse", 32'(bus.frame_err), 32'd0);

    // Backpressure: random valid gaps inside the frame
    send_gap(8'h01, 1'b0);
    send_gap(8'h02, 1'b0);
    send_gap(8'h03, 1'b0);
    send_gap(8'h04, 1'b0);
    send_gap(8'hAB, 1'b0);
    send_gap(8'hCD, 1'b1);
    finish_frame(1'b1, exp16(8'hAB, 8'hCD));

    // Reset while waiting for the controller to finish
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    send(8'h43, 1'b0);
    send(8'h44, 1'b0);
    send(8'hC3, 1'b0);
    send(8'h3C, 1'b1);
    tick();
    bus.crc_rdy = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sready", 32'(bus.s_ready), 32'd1);
    chk("mid_rst_start", 32'(bus.crc_start), 32'd0);
    chk("mid_rst_ok", 32'(bus.frame_ok), 32'd0);
    chk("mid_rst_target", 32'(bus.crc_out_target), 32'h0);
    chk("mid_rst_memdata", 32'(bus.mem_data), 32'h0);
    bus.crc_rdy = 1'b1;
    bus.crc_ok  = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      chk("post_rst_no_done", 32'(bus.frame_done), 32'd0);
      chk("post_rst_no_err", 32'(bus.frame_err), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
